// File: rtl/cycle_seq_pkg.sv
// Shared types and defaults for the multi-cycle instruction sequencer.
package cycle_seq_pkg;

  localparam int DEF_MEM_TIMEOUT = 15;
  localparam int DEF_CNT_W       = 16;
  localparam int TIMER_W         = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6
  } seq_state_t;

  typedef struct packed {
    logic branch;
    logic rd;
    logic wr;
    logic wreg;
  } seq_flags_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEM wait cycles; expired_o marks the last cycle allowed before a timeout.
module mem_wait_timer
  import cycle_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LAST_CNT = TIMER_W'(MEM_TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == LAST_CNT);

endmodule

// File: rtl/cycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer gating IR load, PC update, RF write and data-memory access.
module cycle_sequencer
  import cycle_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             Branch,
  input  logic             ReadMem,
  input  logic             WriteMem,
  input  logic             WriteReg,
  input  logic             BranchCond,
  input  logic             MemAck,
  output logic             IFetchEn,
  output logic             MemReq,
  output logic             MemWe,
  output logic             RegWe,
  output logic             PCInc,
  output logic             PCBranch,
  output logic             Busy,
  output logic             Done,
  output logic             MemErr,
  output logic [CNT_W-1:0] CycleCount
);

  seq_state_t       state_q;
  seq_flags_t       flags_q;
  logic [CNT_W-1:0] cycle_cnt_q;
  logic             mem_err_q;
  logic             timer_expired;
  logic             in_run;

  assign in_run = (state_q != S_IDLE) && (state_q != S_DONE);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i    (CLK),
    .rst_i    (Reset),
    .clr_i    (state_q == S_EXEC),
    .en_i     (state_q == S_MEM),
    .expired_o(timer_expired)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      flags_q     <= '0;
      cycle_cnt_q <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      if (in_run && (cycle_cnt_q != '1)) begin
        cycle_cnt_q <= cycle_cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state_q     <= S_FETCH;
            cycle_cnt_q <= '0;
            mem_err_q   <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          flags_q.branch <= Branch;
          flags_q.rd     <= ReadMem;
          flags_q.wr     <= WriteMem;
          flags_q.wreg   <= WriteReg;
          state_q        <= Halt ? S_DONE : S_EXEC;
        end
        S_EXEC: begin
          if (flags_q.rd || flags_q.wr) begin
            state_q <= S_MEM;
          end else if (flags_q.wreg) begin
            state_q <= S_WB;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_MEM: begin
          // An ack on the expiry cycle still completes the access.
          if (MemAck) begin
            state_q <= flags_q.rd ? S_WB : S_FETCH;
          end else if (timer_expired) begin
            state_q   <= S_DONE;
            mem_err_q <= 1'b1;
          end
        end
        S_WB:    state_q <= S_FETCH;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic exec_last;
  logic branch_taken;
  logic store_last;

  always_comb begin
    exec_last    = (state_q == S_EXEC) && !flags_q.rd && !flags_q.wr && !flags_q.wreg;
    branch_taken = exec_last && flags_q.branch && BranchCond;
    store_last   = (state_q == S_MEM) && MemAck && !flags_q.rd;
    IFetchEn     = (state_q == S_FETCH);
    MemReq       = (state_q == S_MEM);
    MemWe        = (state_q == S_MEM) && flags_q.wr;
    RegWe        = (state_q == S_WB);
    PCBranch     = branch_taken;
    PCInc        = (exec_last && !branch_taken) || store_last || (state_q == S_WB);
    Busy         = in_run;
    Done         = (state_q == S_DONE);
  end

  assign MemErr     = mem_err_q;
  assign CycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Table-driven and randomized checks of cycle_sequencer against an instruction-level latency model.
module tb_cycle_sequencer;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        Reset, Start, Halt, Branch, ReadMem, WriteMem, WriteReg, BranchCond, MemAck;
  logic        IFetchEn, MemReq, MemWe, RegWe, PCInc, PCBranch, Busy, Done, MemErr;
  logic [15:0] CycleCount;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit halt;
    bit br;
    bit rd;
    bit wr;
    bit wreg;
    bit bc;
    int ack_at;  // MEM cycle carrying MemAck, 0 = never
  } instr_t;

  typedef struct {
    instr_t   in;
    int       lat;
    bit [3:0] last;  // {RegWe, PCInc, PCBranch, MemWe} in the final cycle
    bit       err;
  } vec_t;

  logic [8:0] exp_q[$];
  int         ph_q[$];
  logic       prev_done, prev_err;
  int         prev_count;
  vec_t       vecs[10];

  cycle_sequencer #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .Halt(Halt), .Branch(Branch),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .WriteReg(WriteReg),
    .BranchCond(BranchCond), .MemAck(MemAck), .IFetchEn(IFetchEn),
    .MemReq(MemReq), .MemWe(MemWe), .RegWe(RegWe), .PCInc(PCInc),
    .PCBranch(PCBranch), .Busy(Busy), .Done(Done), .MemErr(MemErr),
    .CycleCount(CycleCount)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] outv();
    return {IFetchEn, MemReq, MemWe, RegWe, PCInc, PCBranch, Busy, Done, MemErr};
  endfunction

  function automatic logic [8:0] mk(bit ife, bit mr, bit mwe, bit rwe, bit pci, bit pcb);
    return {ife, mr, mwe, rwe, pci, pcb, 1'b1, 1'b0, 1'b0};
  endfunction

  function automatic instr_t mki(bit halt, bit br, bit rd, bit wr, bit wreg, bit bc, int ack);
    instr_t r;
    r.halt = halt; r.br = br; r.rd = rd; r.wr = wr; r.wreg = wreg; r.bc = bc; r.ack_at = ack;
    return r;
  endfunction

  function automatic vec_t mkv(instr_t in, int lat, bit [3:0] last, bit err);
    vec_t v;
    v.in = in; v.lat = lat; v.last = last; v.err = err;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_rand();
    Start = 1'($urandom); Halt = 1'($urandom); Branch = 1'($urandom);
    ReadMem = 1'($urandom); WriteMem = 1'($urandom); WriteReg = 1'($urandom);
    BranchCond = 1'($urandom); MemAck = 1'($urandom);
  endtask

  task automatic start_prog();
    @(posedge CLK); #1;
    drive_rand();
    Start = 1'b1;
    #3;
    chk("idle_out", 32'(outv()), 32'({7'b0, prev_done, prev_err}));
    chk("idle_cnt", 32'(CycleCount), prev_count);
  endtask

  // Expected per-cycle outputs of one instruction, from its latency rules.
  task automatic build_trace(instr_t in, output bit ends, output bit err);
    int n;
    bit pci;
    exp_q.delete(); ph_q.delete();
    ends = 1'b0; err = 1'b0;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0)); ph_q.push_back(0);
    exp_q.push_back(mk(0, 0, 0, 0, 0, 0)); ph_q.push_back(1);
    if (in.halt) begin
      ends = 1'b1;
      return;
    end
    if (in.rd || in.wr || in.wreg) begin
      exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
    end else begin
      exp_q.push_back(mk(0, 0, 0, 0, !(in.br && in.bc), in.br && in.bc));
    end
    ph_q.push_back(2);
    if (in.rd || in.wr) begin
      n = (in.ack_at >= 1 && in.ack_at <= TO) ? in.ack_at : TO;
      for (int k = 1; k <= n; k++) begin
        pci = (k == in.ack_at) && in.wr && !in.rd;
        exp_q.push_back(mk(0, 1, in.wr, 0, pci, 0)); ph_q.push_back(3);
      end
      if (!(in.ack_at >= 1 && in.ack_at <= TO)) begin
        ends = 1'b1; err = 1'b1;
        return;
      end
      if (in.rd) begin
        exp_q.push_back(mk(0, 0, 0, 1, 1, 0)); ph_q.push_back(4);
      end
    end else if (in.wreg) begin
      exp_q.push_back(mk(0, 0, 0, 1, 1, 0)); ph_q.push_back(4);
    end
  endtask

  task automatic run_instr(instr_t in, inout int cnt, output bit ends, output bit err);
    int k;
    k = 1;
    build_trace(in, ends, err);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge CLK); #1;
      drive_rand();
      case (ph_q[i])
        1: begin
          Halt = in.halt; Branch = in.br; ReadMem = in.rd;
          WriteMem = in.wr; WriteReg = in.wreg;
        end
        2: BranchCond = in.bc;
        3: begin
          MemAck = (k == in.ack_at);
          k++;
        end
        default: ;
      endcase
      #3;
      chk("trace", 32'(outv()), 32'(exp_q[i]));
      chk("count", 32'(CycleCount), cnt);
      cnt++;
    end
  endtask

  task automatic rand_prog();
    int     cnt;
    bit     ends, err;
    instr_t in;
    cnt = 0; ends = 1'b0; err = 1'b0;
    start_prog();
    for (int i = 0; i < 8; i++) begin
      if (ends) break;
      in = mki(0, 0, 0, 0, 0, 1'($urandom), int'($urandom_range(0, 5)));
      case ((i == 7) ? 0 : $urandom_range(0, 8))
        0:       in.halt = 1'b1;
        1, 7:    in.wreg = 1'b1;
        2:       in.br = 1'b1;
        3:       ;
        4:       begin in.rd = 1'b1; in.wreg = 1'($urandom); end
        5:       in.wr = 1'b1;
        6:       begin in.rd = 1'b1; in.wr = 1'b1; end
        default: begin
          in.br = 1'($urandom); in.rd = 1'($urandom);
          in.wr = 1'($urandom); in.wreg = 1'($urandom);
        end
      endcase
      run_instr(in, cnt, ends, err);
    end
    prev_done = 1'b1; prev_err = err; prev_count = cnt;
  endtask

  task automatic run_vec(vec_t v);
    int       n, memcnt;
    bit [3:0] last;
    bit       seen;
    n = 0; memcnt = 0; last = '0; seen = 1'b0;
    start_prog();
    while (n < 40) begin
      @(posedge CLK); #1;
      Start = 1'b0; Halt = 1'b0; Branch = v.in.br; ReadMem = v.in.rd;
      WriteMem = v.in.wr; WriteReg = v.in.wreg; BranchCond = v.in.bc;
      MemAck = (v.in.ack_at != 0) && (memcnt + 1 == v.in.ack_at);
      #3;
      if (n > 0 && (IFetchEn || Done)) begin
        seen = 1'b1;
        break;
      end
      last = {RegWe, PCInc, PCBranch, MemWe};
      memcnt += int'(MemReq);
      n++;
    end
    chk("vec_end_seen", 32'(seen), 1);
    chk("vec_latency", n, v.lat);
    chk("vec_last_cycle", 32'(last), 32'(v.last));
    chk("vec_done", 32'(Done), 32'(v.err));
    chk("vec_memerr", 32'(MemErr), 32'(v.err));
    if (v.err) begin
      chk("vec_err_count", 32'(CycleCount), n);
      prev_count = n;
    end else begin
      @(posedge CLK); #1; Halt = 1'b1;
      @(posedge CLK); #1; Halt = 1'b0; #3;
      chk("vec_halt_done", 32'({Done, Busy}), 32'b10);
      chk("vec_halt_count", 32'(CycleCount), n + 2);
      prev_count = n + 2;
    end
    prev_done = 1'b1; prev_err = v.err;
  endtask

  task automatic reset_check(string name);
    Reset = 1'b1; #1;
    chk(name, 32'({outv(), CycleCount}), 0);
    @(posedge CLK); #1; Reset = 1'b0;
    prev_done = 1'b0; prev_err = 1'b0; prev_count = 0;
  endtask

  initial begin
    Reset = 1'b1; Start = 0; Halt = 0; Branch = 0; ReadMem = 0; WriteMem = 0;
    WriteReg = 0; BranchCond = 0; MemAck = 0;
    prev_done = 1'b0; prev_err = 1'b0; prev_count = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", 32'({outv(), CycleCount}), 0);
    Reset = 1'b0;

    vecs[0] = mkv(mki(0, 0, 0, 0, 1, 0, 0), 4, 4'b1100, 0);  // add
    vecs[1] = mkv(mki(0, 1, 0, 0, 0, 1, 0), 3, 4'b0010, 0);  // bne taken
    vecs[2] = mkv(mki(0, 1, 0, 0, 0, 0, 0), 3, 4'b0100, 0);  // bne not taken
    vecs[3] = mkv(mki(0, 0, 0, 0, 0, 1, 0), 3, 4'b0100, 0);  // nop
    vecs[4] = mkv(mki(0, 0, 1, 0, 1, 0, 3), 7, 4'b1100, 0);  // load, ack 3rd
    vecs[5] = mkv(mki(0, 0, 0, 1, 0, 0, 1), 4, 4'b0101, 0);  // store, ack 1st
    vecs[6] = mkv(mki(0, 0, 0, 1, 0, 0, 4), 7, 4'b0101, 0);  // store, ack on expiry
    vecs[7] = mkv(mki(0, 0, 1, 0, 1, 0, 1), 5, 4'b1100, 0);  // load, ack 1st
    vecs[8] = mkv(mki(0, 0, 1, 1, 0, 0, 2), 6, 4'b1100, 0);  // read+write
    vecs[9] = mkv(mki(0, 0, 0, 1, 0, 0, 0), 7, 4'b0001, 1);  // store timeout
    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i]);
    end

    // Reset in the middle of FETCH.
    start_prog();
    @(posedge CLK); #1; Start = 1'b0; #1;
    chk("fetch_before_reset", 32'(IFetchEn), 1);
    reset_check("reset_mid_fetch");

    // Reset while MemReq is high.
    start_prog();
    @(posedge CLK); #1; Start = 1'b0; WriteMem = 1'b1; ReadMem = 1'b0; Halt = 1'b0; MemAck = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    chk("memreq_before_reset", 32'({MemReq, CycleCount}), 32'({1'b1, 16'd3}));
    reset_check("reset_mid_mem");
    WriteMem = 1'b0;

    for (int p = 0; p < 40; p++) begin
      rand_prog();
    end

    @(posedge CLK); #1; Start = 1'b0; #3;
    chk("final_done", 32'({outv(), CycleCount}), 32'({7'b0, prev_done, prev_err, 16'(prev_count)}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
